// File: rtl/viterbi_pkg.sv
// viterbi_pkg: shared FSM states, default frame sizes and saturating increment for viterbi_frame_ctrl
package viterbi_pkg;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SYNC = 2'd1;
  localparam logic [1:0] RUN  = 2'd2;
  localparam int FRAME_LEN_DEF  = 100;
  localparam int DECODE_LAT_DEF = 18;
  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic [15:0] max);
    return (v == max) ? v : v + 16'd1;
  endfunction
endpackage

// File: rtl/viterbi_ref_delay.sv
// viterbi_ref_delay: DEPTH-deep shift register aligning the encoder input bit with decoder latency
module viterbi_ref_delay
  import viterbi_pkg::*;
#(
  parameter int DEPTH = DECODE_LAT_DEF
) (
  input  logic phi1,
  input  logic reset_n,
  input  logic din,
  output logic dout
);
  logic [DEPTH-1:0] sr;
  always_ff @(posedge phi1 or negedge reset_n)
    if (!reset_n) sr <= '0;
    else sr <= DEPTH'({sr, din});
  assign dout = sr[DEPTH-1];
endmodule

// File: rtl/viterbi_frame_ctrl.sv
// viterbi_frame_ctrl: frame sequencer, decoded-bit checker and result handshake for chip_core.
// Define VITERBI_FAIL_CHECK_EN to count chip fail flags during self-test frames.
module viterbi_frame_ctrl
  import viterbi_pkg::*;
#(
  parameter int FRAME_LEN  = FRAME_LEN_DEF,
  parameter int DECODE_LAT = DECODE_LAT_DEF,
  parameter int ERR_W      = 8
) (
  input  logic             phi1,
  input  logic             reset_n,
  input  logic             start_s1,
  input  logic             stop_s1,
  input  logic             orig_bit_s1,
  input  logic             orig_del_bit_s1,
  input  logic             data_valid_s1,
  input  logic             decoded_bit_s1,
  input  logic             fail_s1,
  output logic             sync_s1,
  output logic             self_test_s1,
  output logic             busy_s1,
  output logic             result_valid_s1,
  input  logic             result_ready_s1,
  output logic [ERR_W-1:0] result_errs_s1,
  output logic             result_mode_s1,
  output logic [ERR_W-1:0] result_cmp_s1,
  output logic             overrun_s1,
  output logic [ERR_W-1:0] fail_count_s1
);
  localparam int CW = $clog2(FRAME_LEN + 1);
  localparam logic [15:0] MAX = 16'((1 << ERR_W) - 1);
  logic [1:0] state;
  logic [CW-1:0] cnt;
  logic sync_q, stop_lat, ref_del, ref_bit, cmp_en, last;
  logic [ERR_W-1:0] errs, cmps, errs_nx, cmps_nx;
  viterbi_ref_delay #(.DEPTH(DECODE_LAT)) u_delay (
    .phi1(phi1),
    .reset_n(reset_n),
    .din(orig_bit_s1),
    .dout(ref_del)
  );
  always_comb begin
    ref_bit = self_test_s1 ? orig_del_bit_s1 : ref_del;
    cmp_en  = data_valid_s1 && state == RUN && !sync_q;
    last    = state == RUN && cnt == CW'(FRAME_LEN);
    cmps_nx = cmp_en ? ERR_W'(sat_inc(16'(cmps), MAX)) : cmps;
    errs_nx = (cmp_en && decoded_bit_s1 != ref_bit) ? ERR_W'(sat_inc(16'(errs), MAX)) : errs;
  end
  assign sync_s1 = state == SYNC;
  assign busy_s1 = state != IDLE;
  always_ff @(posedge phi1 or negedge reset_n)
    if (!reset_n) begin
      state           <= IDLE;
      cnt             <= '0;
      sync_q          <= 1'b0;
      stop_lat        <= 1'b0;
      self_test_s1    <= 1'b0;
      errs            <= '0;
      cmps            <= '0;
      result_valid_s1 <= 1'b0;
      result_errs_s1  <= '0;
      result_cmp_s1   <= '0;
      result_mode_s1  <= 1'b0;
      overrun_s1      <= 1'b0;
    end else begin
      sync_q   <= state == SYNC;
      stop_lat <= (last && stop_lat) ? 1'b0 : stop_lat | (stop_s1 && state != IDLE);
      if (state == IDLE && start_s1) begin
        state        <= SYNC;
        self_test_s1 <= 1'b0;
      end
      if (state == SYNC) begin
        state <= RUN;
        cnt   <= CW'(1);
        errs  <= '0;
        cmps  <= '0;
      end
      if (state == RUN) begin
        cnt  <= last ? '0 : cnt + CW'(1);
        errs <= errs_nx;
        cmps <= cmps_nx;
      end
      if (last) begin
        state          <= stop_lat ? IDLE : SYNC;
        self_test_s1   <= stop_lat ? self_test_s1 : ~self_test_s1;
        result_errs_s1 <= errs_nx;
        result_cmp_s1  <= cmps_nx;
        result_mode_s1 <= self_test_s1;
      end
      // a publish in the same cycle as an accept keeps valid high
      result_valid_s1 <= last | (result_valid_s1 & ~result_ready_s1);
      if (last && result_valid_s1 && !result_ready_s1) overrun_s1 <= 1'b1;
    end
`ifdef VITERBI_FAIL_CHECK_EN
  logic [ERR_W-1:0] fails, fails_nx;
  assign fails_nx = (state == RUN && self_test_s1 && fail_s1) ? ERR_W'(sat_inc(16'(fails), MAX)) : fails;
  always_ff @(posedge phi1 or negedge reset_n)
    if (!reset_n) begin
      fails         <= '0;
      fail_count_s1 <= '0;
    end else begin
      fails <= (state == SYNC) ? '0 : fails_nx;
      if (last) fail_count_s1 <= fails_nx;
    end
`else
  logic unused_fail;
  assign unused_fail   = fail_s1;
  assign fail_count_s1 = '0;
`endif
endmodule
